// File: rtl/cache_line_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_line_bridge_if
// Purpose  : Bundles the cache-side line request/fill signals and the
//            mem_arb client-port signals of one cache_line_bridge.
//            "slave" is the bridge's view, "master" the environment's view.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_line_bridge_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2
);
  localparam int LINE_WORDS = 2 ** BURSTLEN_WIDTH;

  // cache controller side
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_wr;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata;
  logic                             fill_word_valid;
  logic [BURSTLEN_WIDTH-1:0]        fill_word_idx;
  logic [DATA_WIDTH-1:0]            fill_word;
  logic [LINE_WORDS*DATA_WIDTH-1:0] rdata_line;
  logic                             done;

  // mem_arb client side
  logic [ADDR_WIDTH-1:0]            mm_addr;
  logic [BURSTLEN_WIDTH-1:0]        mm_burst_len;
  logic [DATA_WIDTH-1:0]            mm_data_out;
  logic [DATA_WIDTH-1:0]            mm_data_in;
  logic                             mm_wr;
  logic                             mm_rd;
  logic                             mm_waitrequest;
  logic                             mm_rd_valid;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  mm_data_in, mm_waitrequest, mm_rd_valid,
    output req_ready, fill_word_valid, fill_word_idx, fill_word, rdata_line, done,
    output mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output mm_data_in, mm_waitrequest, mm_rd_valid,
    input  req_ready, fill_word_valid, fill_word_idx, fill_word, rdata_line, done,
    input  mm_addr, mm_burst_len, mm_data_out, mm_wr, mm_rd
  );
endinterface
`default_nettype wire

// File: rtl/cache_line_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_line_bridge
// Purpose  : Turns whole-line fill / writeback requests into one mem_arb
//            burst. Fills are critical-word-first with wrap, each word is
//            forwarded as it arrives; writebacks are line-aligned, sequential.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  cache_line_bridge_if.slave bus
);
  localparam int LINE_WORDS = 2 ** BURSTLEN_WIDTH;
  localparam logic [BURSTLEN_WIDTH-1:0] LAST_BEAT = BURSTLEN_WIDTH'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0]     WORD_STEP = ADDR_WIDTH'(4);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_REQ  = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_WR      = 2'd3;

  logic [1:0]                                state;
  logic [1:0]                                state_next;
  logic [BURSTLEN_WIDTH-1:0]                 beat;
  logic [BURSTLEN_WIDTH-1:0]                 beat_inc;
  logic [BURSTLEN_WIDTH-1:0]                 word_idx;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]     wr_words;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]     line_words;
  logic [ADDR_WIDTH-1:0]                     mm_addr_reg;
  logic [DATA_WIDTH-1:0]                     mm_data_reg;
  logic                                      mm_rd_reg;
  logic                                      mm_wr_reg;
  logic                                      done_reg;
  logic                                      fill_valid_reg;
  logic [BURSTLEN_WIDTH-1:0]                 fill_idx_reg;
  logic [DATA_WIDTH-1:0]                     fill_data_reg;
  logic                                      ready;
  logic                                      accept;
  logic                                      last_beat;
  logic                                      mm_rd_next;
  logic                                      mm_wr_next;
  logic                                      done_next;
  logic                                      unused_addr_bits;

  // Byte-lane bits never matter: both burst kinds are word addressed.
  assign unused_addr_bits = ^bus.req_addr[1:0];

  assign accept    = bus.req_valid && ready;
  assign last_beat = (beat == LAST_BEAT);
  assign beat_inc  = beat + 1'b1;

  assign bus.req_ready       = ready;
  assign bus.mm_addr         = mm_addr_reg;
  assign bus.mm_data_out     = mm_data_reg;
  assign bus.mm_rd           = mm_rd_reg;
  assign bus.mm_wr           = mm_wr_reg;
  assign bus.mm_burst_len    = LAST_BEAT;
  assign bus.done            = done_reg;
  assign bus.fill_word_valid = fill_valid_reg;
  assign bus.fill_word_idx   = fill_idx_reg;
  assign bus.fill_word       = fill_data_reg;
  assign bus.rdata_line      = line_words;

  // State register; a reset mid-burst simply abandons the transfer.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state: a burst ends on the last granted write beat or last read beat.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept) state_next = bus.req_wr ? S_WR : S_RD_REQ;
      S_RD_REQ:  if (!bus.mm_waitrequest) state_next = S_RD_DATA;
      S_RD_DATA: if (bus.mm_rd_valid && last_beat) state_next = S_IDLE;
      S_WR:      if (!bus.mm_waitrequest && last_beat) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs: mm_rd/mm_wr/done are registered copies of the coming state, so
  // the request strobes follow the state one cycle after the decision.
  always_comb begin
    ready      = (state == S_IDLE) && reset_n;
    mm_rd_next = (state_next == S_RD_REQ);
    mm_wr_next = (state_next == S_WR);
    done_next  = (state != S_IDLE) && (state_next == S_IDLE);
  end

  // Datapath: latch the request, advance write beats on grant, collect fill words.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      beat           <= '0;
      word_idx       <= '0;
      wr_words       <= '0;
      line_words     <= '0;
      mm_addr_reg    <= '0;
      mm_data_reg    <= '0;
      mm_rd_reg      <= 1'b0;
      mm_wr_reg      <= 1'b0;
      done_reg       <= 1'b0;
      fill_valid_reg <= 1'b0;
      fill_idx_reg   <= '0;
      fill_data_reg  <= '0;
    end else begin
      mm_rd_reg      <= mm_rd_next;
      mm_wr_reg      <= mm_wr_next;
      done_reg       <= done_next;
      fill_valid_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            beat     <= '0;
            word_idx <= bus.req_addr[BURSTLEN_WIDTH+1:2];
            wr_words <= bus.req_wdata;
            if (bus.req_wr) begin
              mm_addr_reg <= {bus.req_addr[ADDR_WIDTH-1:BURSTLEN_WIDTH+2],
                              {(BURSTLEN_WIDTH+2){1'b0}}};
              mm_data_reg <= bus.req_wdata[DATA_WIDTH-1:0];
            end else begin
              mm_addr_reg <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        S_RD_DATA: begin
          if (bus.mm_rd_valid) begin
            line_words[word_idx] <= bus.mm_data_in;
            fill_valid_reg       <= 1'b1;
            fill_idx_reg         <= word_idx;
            fill_data_reg        <= bus.mm_data_in;
            word_idx             <= word_idx + 1'b1;
            beat                 <= beat_inc;
          end
        end
        S_WR: begin
          // Address/data move only after a grant, so they are stable under stall.
          if (!bus.mm_waitrequest && !last_beat) begin
            beat        <= beat_inc;
            mm_addr_reg <= mm_addr_reg + WORD_STEP;
            mm_data_reg <= wr_words[beat_inc];
          end
        end
        default: ;
      endcase
    end
  end

  // Read data arriving outside the data phase means the arbiter misrouted a beat.
  a_rd_valid_in_data: assert property (@(posedge clock) disable iff (!reset_n)
    bus.mm_rd_valid |-> (state == S_RD_DATA));

endmodule
`default_nettype wire

// File: tb/tb_cache_line_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_bridge
// Purpose  : Directed + random bench for cache_line_bridge with a simple
//            mem_arb client responder and expectation queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 2;
  localparam int LW = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  cache_line_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) bus ();

  cache_line_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0]  mem     [0:255];   // memory behind the responder
  logic [31:0]  ref_mem [0:255];   // reference contents used for expectations
  logic [33:0]  fill_q  [$];       // {idx, word}
  logic [128:0] done_q  [$];       // {is_write, line}
  logic [63:0]  wbeat_q [$];       // {addr, data}
  logic [31:0]  raddr_q [$];
  int           lat_q   [$];
  int done_cnt = 0;
  int fill_cnt = 0;
  int done_cyc = 0;
  int rdv_cyc  = 0;

  // responder knobs
  int rd_wait         = 0;
  int rd_gap [LW]     = '{0, 0, 0, 0};
  int wr_stall_beat   = -1;
  int wr_stall_cycles = 0;
  bit rnd             = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  // mem_arb client model: drives waitrequest / read data on the falling edge.
  initial begin : responder
    int rd_left, rd_word, gap, waited, wr_beat;
    bit stall;
    rd_left = 0; rd_word = 0; gap = 0; waited = 0; wr_beat = 0;
    bus.mm_waitrequest = 1'b1;
    bus.mm_rd_valid    = 1'b0;
    bus.mm_data_in     = '0;
    forever begin
      @(negedge clock);
      bus.mm_rd_valid    = 1'b0;
      bus.mm_waitrequest = 1'b1;
      if (!reset_n) begin
        rd_left = 0; waited = 0; wr_beat = 0;
      end else if (rd_left > 0) begin
        if (gap > 0) gap--;
        else begin
          bus.mm_rd_valid = 1'b1;
          bus.mm_data_in  = mem[rd_word];
          rd_word = (rd_word & ~3) | ((rd_word + 1) & 3);
          rd_left--;
          if (rd_left > 0) gap = rnd ? int'($urandom_range(0, 2)) : rd_gap[LW - rd_left];
        end
      end else if (bus.mm_rd) begin
        stall = rnd ? ($urandom_range(0, 2) == 0) : (waited < rd_wait);
        if (stall) waited++;
        else begin
          bus.mm_waitrequest = 1'b0;
          waited  = 0;
          rd_left = LW;
          rd_word = int'(bus.mm_addr[9:2]);
          gap     = rnd ? int'($urandom_range(0, 2)) : rd_gap[0];
        end
      end else if (bus.mm_wr) begin
        stall = rnd ? ($urandom_range(0, 2) == 0)
                    : (wr_beat == wr_stall_beat && waited < wr_stall_cycles);
        if (stall) waited++;
        else begin
          bus.mm_waitrequest = 1'b0;
          waited = 0;
          mem[bus.mm_addr[9:2]] = bus.mm_data_out;
          wr_beat++;
        end
      end else begin
        waited = 0; wr_beat = 0;
      end
    end
  end

  // Output monitor: pops expectations as the bridge produces results.
  initial begin : monitor
    logic [63:0] prev_beat;
    bit          prev_stall;
    logic [128:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) prev_stall = 1'b0;
      else begin
        if (bus.mm_rd && !bus.mm_waitrequest) begin
          chk("rd_q_nonempty", raddr_q.size() != 0, 1);
          if (raddr_q.size() != 0) chk("rd_addr", bus.mm_addr, raddr_q.pop_front());
          chk("burst_len", bus.mm_burst_len, 3);
        end
        if (bus.mm_rd_valid) begin
          lat_q.push_back(cyc + 1);
          rdv_cyc = cyc;
        end
        if (bus.fill_word_valid) begin
          fill_cnt++;
          chk("fill_q_nonempty", fill_q.size() != 0, 1);
          if (fill_q.size() != 0) chk("fill_word", {bus.fill_word_idx, bus.fill_word}, fill_q.pop_front());
          if (lat_q.size() != 0) chk("fill_latency", cyc, lat_q.pop_front());
        end
        if (bus.mm_wr) begin
          if (prev_stall) chk("wr_hold", {bus.mm_addr, bus.mm_data_out}, prev_beat);
          if (!bus.mm_waitrequest) begin
            chk("wr_q_nonempty", wbeat_q.size() != 0, 1);
            if (wbeat_q.size() != 0) chk("wr_beat", {bus.mm_addr, bus.mm_data_out}, wbeat_q.pop_front());
          end
          prev_stall = bus.mm_waitrequest;
          prev_beat  = {bus.mm_addr, bus.mm_data_out};
        end else prev_stall = 1'b0;
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_q_nonempty", done_q.size() != 0, 1);
          if (done_q.size() != 0) begin
            e = done_q.pop_front();
            if (e[128]) chk("wr_beats_left", wbeat_q.size(), 0);
            else        chk("rdata_line", bus.rdata_line, e[127:0]);
          end
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [127:0] line);
    int n;
    int base;
    logic [1:0]   crit;
    logic [1:0]   idx;
    logic [127:0] exp_line;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin step(); n++; end
    chk("req_ready_wait", n < 200, 1);
    base = int'(addr[9:4]) * 4;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = line;
    if (wr) begin
      for (int k = 0; k < LW; k++) begin
        wbeat_q.push_back({(addr & 32'hFFFF_FFF0) + 32'(4 * k), line[k*DW +: DW]});
        ref_mem[base + k] = line[k*DW +: DW];
      end
      done_q.push_back({1'b1, line});
    end else begin
      crit     = addr[3:2];
      exp_line = '0;
      for (int k = 0; k < LW; k++) begin
        idx = crit + 2'(k);
        fill_q.push_back({idx, ref_mem[base + int'(idx)]});
        exp_line[int'(idx)*DW +: DW] = ref_mem[base + int'(idx)];
      end
      raddr_q.push_back({addr[31:2], 2'b00});
      done_q.push_back({1'b0, exp_line});
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin step(); n++; end
    chk("done_count", done_cnt, target);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int f0;
    int n;
    int target;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end

    // reset state
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mm_rd", bus.mm_rd, 0);
    chk("rst_mm_wr", bus.mm_wr, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fill_valid", bus.fill_word_valid, 0);
    chk("rst_mm_addr", bus.mm_addr, 0);
    chk("rst_mm_data_out", bus.mm_data_out, 0);
    chk("rst_rdata_line", bus.rdata_line, 0);
    reset_n = 1'b1;
    step();
    chk("idle_req_ready", bus.req_ready, 1);

    // 1: aligned fill, words 0x10..0x13
    send(1'b0, 32'h40, '0);
    wait_done(1);
    repeat (3) step();
    chk("t1_single_done", done_cnt, 1);

    // 2: critical-word fill, idx 2,3,0,1; requests while busy are ignored
    send(1'b0, 32'h48, '0);
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'h200;
    bus.req_valid = 1'b1;
    chk("busy_ready_0", bus.req_ready, 0);
    step();
    chk("busy_ready_1", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    wait_done(2);

    // 3: writeback with beat 1 stalled three cycles
    wr_stall_beat   = 1;
    wr_stall_cycles = 3;
    send(1'b1, 32'h100, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    wait_done(3);
    chk("t3_mem40", mem[8'h40], 32'hAAAA_0001);
    chk("t3_mem41", mem[8'h41], 32'hBBBB_0002);
    chk("t3_mem42", mem[8'h42], 32'hCCCC_0003);
    chk("t3_mem43", mem[8'h43], 32'hDDDD_0004);
    wr_stall_beat   = -1;
    wr_stall_cycles = 0;

    // 4: fill with read-valid gaps 0/2/1 and a stalled grant
    rd_gap  = '{0, 0, 2, 1};
    rd_wait = 2;
    f0 = fill_cnt;
    send(1'b0, 32'h84, '0);
    wait_done(4);
    chk("t4_fill_pulses", fill_cnt - f0, 4);
    chk("t4_done_latency", done_cyc, rdv_cyc + 1);
    rd_gap  = '{0, 0, 0, 0};
    rd_wait = 0;

    // 5: reset after two fill words, then a clean fill at 0x0
    f0 = fill_cnt;
    send(1'b0, 32'hC4, '0);
    n = 0;
    while (fill_cnt < f0 + 2 && n < 100) begin step(); n++; end
    chk("t5_two_words", fill_cnt - f0, 2);
    reset_n = 1'b0;
    fill_q.delete();
    done_q.delete();
    raddr_q.delete();
    lat_q.delete();
    wbeat_q.delete();
    step();
    chk("t5_mm_rd", bus.mm_rd, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_fill_valid", bus.fill_word_valid, 0);
    chk("t5_req_ready", bus.req_ready, 0);
    step();
    reset_n = 1'b1;
    step();
    send(1'b0, 32'h0, '0);
    wait_done(5);

    // 6: random fills/writebacks, random stalls and gaps, back-to-back issue
    rnd    = 1'b1;
    target = done_cnt + 300;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
           {$urandom, $urandom, $urandom, $urandom});
    end
    wait_done(target);
    repeat (4) step();
    chk("end_fill_q", fill_q.size(), 0);
    chk("end_done_q", done_q.size(), 0);
    chk("end_wbeat_q", wbeat_q.size(), 0);
    chk("end_raddr_q", raddr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
